// File: rtl/sram_access_ctrl.sv
`timescale 1ns/1ps
// Single-word SRAM access controller feeding a bus buffer that registers write
// data for one cycle and returns the bus value sampled at the previous edge.
module sram_access_ctrl #(
  parameter int N           = 16,
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [N-1:0]      req_wdata,
  input  logic [1:0]        req_be,
  output logic              rsp_valid,
  output logic [N-1:0]      rsp_rdata,
  output logic              CE_N,
  output logic              OE_N,
  output logic              WE_N,
  output logic              UB_N,
  output logic              LB_N,
  output logic [ADDR_W-1:0] ADDR,
  output logic              tristate_output_enable,
  output logic [N-1:0]      Data_write,
  input  logic [N-1:0]      Data_read
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_ACCESS  = 3'd1,
    RD_CAPTURE = 3'd2,
    WR_SETUP   = 3'd3,
    WR_PULSE   = 3'd4,
    WR_HOLD    = 3'd5
  } state_t;

  // WAIT_CYCLES is limited to 0..7, so a 3-bit counter covers every stretch.
  localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES);

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [N-1:0]        wdata_q, wdata_d;
  logic                ub_n_q, ub_n_d;
  logic                lb_n_q, lb_n_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                toe_q, toe_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [N-1:0]        rsp_rdata_q, rsp_rdata_d;
  logic                accept;

  assign req_ready = (state_q == IDLE) && !Reset;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = 3'd0;
          state_d = req_we ? WR_SETUP : RD_ACCESS;
        end
      end
      RD_ACCESS: begin
        if (cnt_q == LAST_CNT) begin
          state_d = RD_CAPTURE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      // Data_read now carries the bus value from the last access edge.
      RD_CAPTURE: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = Data_read;
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        if (cnt_q == LAST_CNT) begin
          state_d = WR_HOLD;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WR_HOLD: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ub_n_d  = ub_n_q;
    lb_n_d  = lb_n_q;
    if (accept) begin
      addr_d  = req_addr;
      wdata_d = req_wdata;
      ub_n_d  = ~req_be[1];
      lb_n_d  = ~req_be[0];
    end
  end

  // Pins are decoded from the next state and registered so the SRAM never
  // sees decode glitches; they change on the same edge as the state.
  always_comb begin
    ce_n_d = 1'b1;
    oe_n_d = 1'b1;
    we_n_d = 1'b1;
    toe_d  = 1'b0;
    case (state_d)
      RD_ACCESS, RD_CAPTURE: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
      WR_SETUP: begin
        ce_n_d = 1'b0;
      end
      WR_PULSE: begin
        ce_n_d = 1'b0;
        we_n_d = 1'b0;
        toe_d  = 1'b1;
      end
      WR_HOLD: begin
        ce_n_d = 1'b0;
        toe_d  = 1'b1;
      end
      default: begin
        ce_n_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ub_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      toe_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ub_n_q      <= ub_n_d;
      lb_n_q      <= lb_n_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      toe_q       <= toe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign CE_N                   = ce_n_q;
  assign OE_N                   = oe_n_q;
  assign WE_N                   = we_n_q;
  assign UB_N                   = ub_n_q;
  assign LB_N                   = lb_n_q;
  assign ADDR                   = addr_q;
  assign Data_write             = wdata_q;
  assign tristate_output_enable = toe_q;
  assign rsp_valid              = rsp_valid_q;
  assign rsp_rdata              = rsp_rdata_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
`timescale 1ns/1ps
// Bench for sram_access_ctrl: three instances (WAIT_CYCLES 1, 0, 3) each on a
// bus-buffer + byte-lane SRAM model, checked against an array reference memory.
module tb_sram_access_ctrl;

  localparam int NDUT = 3;
  localparam int MSZ  = 1024;

  logic clk = 1'b0;
  logic rst;

  logic        req_valid [NDUT];
  logic        req_ready [NDUT];
  logic        req_we    [NDUT];
  logic [19:0] req_addr  [NDUT];
  logic [15:0] req_wdata [NDUT];
  logic [1:0]  req_be    [NDUT];
  logic        rsp_valid [NDUT];
  logic [15:0] rsp_rdata [NDUT];
  logic        ce_n      [NDUT];
  logic        oe_n      [NDUT];
  logic        we_n      [NDUT];
  logic        ub_n      [NDUT];
  logic        lb_n      [NDUT];
  logic [19:0] addr_o    [NDUT];
  logic        toe       [NDUT];
  logic [15:0] data_write[NDUT];
  logic [15:0] data_read [NDUT];
  logic [15:0] wd_reg    [NDUT];
  logic [15:0] bus       [NDUT];

  logic [15:0] smem    [0:NDUT*MSZ-1] = '{default: 16'hFFFF};
  logic [15:0] ref_mem [0:NDUT*MSZ-1];

  int n_cmp = 0;
  int n_bad = 0;

  int          obs_lat, obs_viol, obs_we_low, obs_ce_high, obs_ub_bad, obs_lb_bad;
  int          obs_addr_bad, obs_dw_bad, obs_busy_ready;
  logic        obs_rdy_at_rsp, obs_idle_pins, obs_acc_ready;
  logic [15:0] obs_rdata;

  always #5 clk = ~clk;

  sram_access_ctrl #(.N(16), .ADDR_W(20), .WAIT_CYCLES(1)) dut_w1 (
    .Clk(clk), .Reset(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .CE_N(ce_n[0]), .OE_N(oe_n[0]),
    .WE_N(we_n[0]), .UB_N(ub_n[0]), .LB_N(lb_n[0]), .ADDR(addr_o[0]),
    .tristate_output_enable(toe[0]), .Data_write(data_write[0]), .Data_read(data_read[0]));

  sram_access_ctrl #(.N(16), .ADDR_W(20), .WAIT_CYCLES(0)) dut_w0 (
    .Clk(clk), .Reset(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .CE_N(ce_n[1]), .OE_N(oe_n[1]),
    .WE_N(we_n[1]), .UB_N(ub_n[1]), .LB_N(lb_n[1]), .ADDR(addr_o[1]),
    .tristate_output_enable(toe[1]), .Data_write(data_write[1]), .Data_read(data_read[1]));

  sram_access_ctrl #(.N(16), .ADDR_W(20), .WAIT_CYCLES(3)) dut_w3 (
    .Clk(clk), .Reset(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
    .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .CE_N(ce_n[2]), .OE_N(oe_n[2]),
    .WE_N(we_n[2]), .UB_N(ub_n[2]), .LB_N(lb_n[2]), .ADDR(addr_o[2]),
    .tristate_output_enable(toe[2]), .Data_write(data_write[2]), .Data_read(data_read[2]));

  // Bus: buffer drives its registered write data; SRAM drives enabled byte lanes
  // while reading; undriven lanes read as zero.
  always_comb begin
    for (int i = 0; i < NDUT; i++) begin
      if (toe[i]) begin
        bus[i] = wd_reg[i];
      end else if (!ce_n[i] && !oe_n[i] && we_n[i]) begin
        bus[i] = {ub_n[i] ? 8'h00 : smem[i*MSZ + int'(addr_o[i][9:0])][15:8],
                  lb_n[i] ? 8'h00 : smem[i*MSZ + int'(addr_o[i][9:0])][7:0]};
      end else begin
        bus[i] = 16'h0000;
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      wd_reg[i]    <= data_write[i];
      data_read[i] <= bus[i];
      if (!ce_n[i] && !we_n[i]) begin
        if (!ub_n[i]) smem[i*MSZ + int'(addr_o[i][9:0])][15:8] <= bus[i][15:8];
        if (!lb_n[i]) smem[i*MSZ + int'(addr_o[i][9:0])][7:0]  <= bus[i][7:0];
      end
    end
  end

  function automatic int wait_of(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic void ref_write(input int d, input logic [19:0] a, input logic [15:0] wd,
                                    input logic [1:0] be);
    if (be[1]) ref_mem[d*MSZ + int'(a[9:0])][15:8] = wd[15:8];
    if (be[0]) ref_mem[d*MSZ + int'(a[9:0])][7:0]  = wd[7:0];
  endfunction

  function automatic logic [15:0] ref_read(input int d, input logic [19:0] a, input logic [1:0] be);
    logic [15:0] w;
    w = ref_mem[d*MSZ + int'(a[9:0])];
    return {be[1] ? w[15:8] : 8'h00, be[0] ? w[7:0] : 8'h00};
  endfunction

  // Issues one request (called #1 after an edge) and records what the pins did
  // until rsp_valid, returning in the rsp_valid cycle. Cycle 1 follows the accept edge.
  task automatic do_op(input int d, input logic we, input logic [19:0] a, input logic [15:0] wd,
                       input logic [1:0] be, input logic hold);
    obs_lat = -1; obs_viol = 0; obs_we_low = 0; obs_ce_high = 0; obs_ub_bad = 0;
    obs_lb_bad = 0; obs_addr_bad = 0; obs_dw_bad = 0; obs_busy_ready = 0;
    obs_rdy_at_rsp = 1'b0; obs_idle_pins = 1'b0; obs_rdata = 16'h0000;
    obs_acc_ready = req_ready[d];
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = a; req_wdata[d] = wd; req_be[d] = be;
    @(posedge clk); #1;
    if (!hold) begin
      req_valid[d] = 1'b0;
      req_we[d]    = 1'($urandom_range(0, 1));
      req_addr[d]  = 20'($urandom);
      req_wdata[d] = 16'($urandom);
      req_be[d]    = 2'($urandom_range(0, 3));
    end
    for (int k = 1; k <= 40; k++) begin
      if (toe[d] && !oe_n[d]) obs_viol++;
      if (!we_n[d] && !toe[d]) obs_viol++;
      if (toe[d] && !we) obs_viol++;
      if (!we_n[d]) obs_we_low++;
      if (ub_n[d] !== ~be[1]) obs_ub_bad++;
      if (lb_n[d] !== ~be[0]) obs_lb_bad++;
      if (addr_o[d] !== a) obs_addr_bad++;
      if (we && data_write[d] !== wd) obs_dw_bad++;
      if (rsp_valid[d]) begin
        obs_lat        = k;
        obs_rdata      = rsp_rdata[d];
        obs_rdy_at_rsp = req_ready[d];
        obs_idle_pins  = ce_n[d] & oe_n[d] & we_n[d] & ~toe[d];
        break;
      end
      if (ce_n[d]) obs_ce_high++;
      if (req_ready[d]) obs_busy_ready++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      n_cmp++;
      if ({ce_n[d], oe_n[d], we_n[d], ub_n[d], lb_n[d]} !== 5'b11111) begin
        n_bad++;
        $display("FAIL reset_pins dut%0d: got %b want 11111", d, {ce_n[d], oe_n[d], we_n[d], ub_n[d], lb_n[d]});
      end
      n_cmp++;
      if (addr_o[d] !== 20'h0 || data_write[d] !== 16'h0 || rsp_rdata[d] !== 16'h0) begin
        n_bad++;
        $display("FAIL reset_data dut%0d: got addr=%h dw=%h rd=%h want all zero", d, addr_o[d], data_write[d], rsp_rdata[d]);
      end
      n_cmp++;
      if ({toe[d], rsp_valid[d], req_ready[d]} !== 3'b000) begin
        n_bad++;
        $display("FAIL reset_flags dut%0d: got toe/rsp/ready=%b want 000", d, {toe[d], rsp_valid[d], req_ready[d]});
      end
    end
    #2 rst = 1'b0;
    #1;
    @(posedge clk); #1;
    for (int d = 0; d < NDUT; d++) begin
      n_cmp++;
      if (req_ready[d] !== 1'b1) begin
        n_bad++;
        $display("FAIL ready_after_reset dut%0d: got %b want 1", d, req_ready[d]);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_write_read();
    logic [15:0] prev;
    logic [15:0] exp;
    prev = rsp_rdata[0];
    do_op(0, 1'b1, 20'h00123, 16'hBEEF, 2'b11, 1'b0);
    ref_write(0, 20'h00123, 16'hBEEF, 2'b11);
    $display("write addr=00123 data=beef lat=%0d we_low=%0d", obs_lat, obs_we_low);
    n_cmp++;
    if (obs_lat !== wait_of(0) + 4) begin
      n_bad++; $display("FAIL wr_latency: got %0d want %0d", obs_lat, wait_of(0) + 4);
    end
    n_cmp++;
    if (obs_we_low !== wait_of(0) + 1) begin
      n_bad++; $display("FAIL wr_we_low_cycles: got %0d want %0d", obs_we_low, wait_of(0) + 1);
    end
    n_cmp++;
    if (obs_rdata !== prev) begin
      n_bad++; $display("FAIL wr_rdata_hold: got %h want %h", obs_rdata, prev);
    end
    n_cmp++;
    if (obs_addr_bad != 0 || obs_dw_bad != 0 || obs_viol != 0) begin
      n_bad++; $display("FAIL wr_pins: got addr_bad=%0d dw_bad=%0d viol=%0d want 0/0/0", obs_addr_bad, obs_dw_bad, obs_viol);
    end
    exp = ref_read(0, 20'h00123, 2'b11);
    do_op(0, 1'b0, 20'h00123, 16'h5A5A, 2'b11, 1'b0);
    $display("read addr=00123 data=%h lat=%0d", obs_rdata, obs_lat);
    n_cmp++;
    if (obs_lat !== wait_of(0) + 3) begin
      n_bad++; $display("FAIL rd_latency: got %0d want %0d", obs_lat, wait_of(0) + 3);
    end
    n_cmp++;
    if (obs_rdata !== exp) begin
      n_bad++; $display("FAIL rd_data: got %h want %h", obs_rdata, exp);
    end
    n_cmp++;
    if (obs_rdy_at_rsp !== 1'b1 || obs_idle_pins !== 1'b1 || obs_busy_ready != 0) begin
      n_bad++; $display("FAIL rd_ready_idle: got rdy_rsp=%b idle=%b busy_rdy=%0d want 1/1/0", obs_rdy_at_rsp, obs_idle_pins, obs_busy_ready);
    end
  endtask

  task automatic test_byte_enable();
    logic [15:0] exp;
    do_op(0, 1'b1, 20'h00200, 16'h1234, 2'b01, 1'b0);
    ref_write(0, 20'h00200, 16'h1234, 2'b01);
    $display("write addr=00200 data=1234 be=01 lat=%0d", obs_lat);
    n_cmp++;
    if (obs_ub_bad != 0 || obs_lb_bad != 0) begin
      n_bad++; $display("FAIL be_lanes: got ub_bad=%0d lb_bad=%0d want 0/0", obs_ub_bad, obs_lb_bad);
    end
    exp = ref_read(0, 20'h00200, 2'b11);
    do_op(0, 1'b0, 20'h00200, 16'h0000, 2'b11, 1'b0);
    $display("read addr=00200 data=%h", obs_rdata);
    n_cmp++;
    if (obs_rdata !== exp) begin
      n_bad++; $display("FAIL be_read: got %h want %h", obs_rdata, exp);
    end
  endtask

  task automatic test_zero_be();
    logic [15:0] exp;
    do_op(0, 1'b1, 20'h00040, 16'h0BAD, 2'b00, 1'b0);
    ref_write(0, 20'h00040, 16'h0BAD, 2'b00);
    $display("write addr=00040 be=00 lat=%0d", obs_lat);
    n_cmp++;
    if (obs_lat !== wait_of(0) + 4 || obs_ub_bad != 0 || obs_lb_bad != 0) begin
      n_bad++; $display("FAIL be00_write: got lat=%0d ub_bad=%0d lb_bad=%0d want %0d/0/0", obs_lat, obs_ub_bad, obs_lb_bad, wait_of(0) + 4);
    end
    exp = ref_read(0, 20'h00040, 2'b11);
    do_op(0, 1'b0, 20'h00040, 16'h0000, 2'b11, 1'b0);
    $display("read addr=00040 data=%h", obs_rdata);
    n_cmp++;
    if (obs_rdata !== exp) begin
      n_bad++; $display("FAIL be00_unchanged: got %h want %h", obs_rdata, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] wd;
    logic [15:0] exp;
    for (int a = 0; a < 3; a++) begin
      wd = 16'($urandom);
      do_op(0, 1'b1, 20'(a), wd, 2'b11, 1'b0);
      ref_write(0, 20'(a), wd, 2'b11);
    end
    for (int a = 0; a < 3; a++) begin
      exp = ref_read(0, 20'(a), 2'b11);
      do_op(0, 1'b0, 20'(a), 16'h0000, 2'b11, 1'b1);
      $display("b2b read addr=%0d data=%h spacing=%0d", a, obs_rdata, obs_lat);
      n_cmp++;
      if (obs_lat !== wait_of(0) + 3 || obs_acc_ready !== 1'b1) begin
        n_bad++; $display("FAIL b2b_spacing%0d: got lat=%0d ready=%b want %0d/1", a, obs_lat, obs_acc_ready, wait_of(0) + 3);
      end
      n_cmp++;
      if (obs_rdata !== exp) begin
        n_bad++; $display("FAIL b2b_data%0d: got %h want %h", a, obs_rdata, exp);
      end
      n_cmp++;
      if (obs_ce_high != 0) begin
        n_bad++; $display("FAIL b2b_ce%0d: got %0d busy cycles with CE_N=1 want 0", a, obs_ce_high);
      end
    end
    req_valid[0] = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    int rsp_seen;
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 20'h003FF;
    req_wdata[0] = 16'($urandom); req_be[0] = 2'b11;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (we_n[0] !== 1'b0 || toe[0] !== 1'b1) begin
      n_bad++; $display("FAIL mid_pulse: got we_n=%b toe=%b want 0/1", we_n[0], toe[0]);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({we_n[0], toe[0], ce_n[0], req_ready[0], rsp_valid[0]} !== 5'b10100) begin
      n_bad++; $display("FAIL async_reset: got we_n/toe/ce_n/ready/rsp=%b want 10100", {we_n[0], toe[0], ce_n[0], req_ready[0], rsp_valid[0]});
    end
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    n_cmp++;
    if (req_ready[0] !== 1'b1) begin
      n_bad++; $display("FAIL ready_after_abort: got %b want 1", req_ready[0]);
    end
    rsp_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (rsp_valid[0] || !req_ready[0]) rsp_seen++;
    end
    $display("reset mid-write: stray cycles=%0d", rsp_seen);
    n_cmp++;
    if (rsp_seen != 0) begin
      n_bad++; $display("FAIL abort_no_rsp: got %0d stray cycles want 0", rsp_seen);
    end
  endtask

  task automatic test_random(input int d, input int count);
    logic        we;
    logic [19:0] a;
    logic [15:0] wd;
    logic [1:0]  be;
    logic [15:0] exp;
    int          exp_lat;
    int          gap;
    for (int i = 0; i < count; i++) begin
      we  = 1'($urandom_range(0, 1));
      a   = 20'($urandom_range(0, 63));
      wd  = 16'($urandom);
      be  = 2'($urandom_range(0, 3));
      exp = we ? rsp_rdata[d] : ref_read(d, a, be);
      exp_lat = wait_of(d) + (we ? 4 : 3);
      do_op(d, we, a, wd, be, 1'b0);
      if (we) ref_write(d, a, wd, be);
      $display("rand dut%0d #%0d %s addr=%h be=%b wd=%h rd=%h lat=%0d", d, i, we ? "WR" : "RD", a, be, wd, obs_rdata, obs_lat);
      n_cmp++;
      if (obs_lat !== exp_lat) begin
        n_bad++; $display("FAIL rand_latency dut%0d #%0d: got %0d want %0d", d, i, obs_lat, exp_lat);
      end
      n_cmp++;
      if (obs_rdata !== exp) begin
        n_bad++; $display("FAIL rand_rdata dut%0d #%0d: got %h want %h", d, i, obs_rdata, exp);
      end
      n_cmp++;
      if (obs_viol != 0) begin
        n_bad++; $display("FAIL rand_contention dut%0d #%0d: got %0d violations want 0", d, i, obs_viol);
      end
      n_cmp++;
      if (obs_we_low !== (we ? wait_of(d) + 1 : 0)) begin
        n_bad++; $display("FAIL rand_we_low dut%0d #%0d: got %0d want %0d", d, i, obs_we_low, we ? wait_of(d) + 1 : 0);
      end
      n_cmp++;
      if (obs_addr_bad + obs_ub_bad + obs_lb_bad + obs_dw_bad + obs_ce_high + obs_busy_ready != 0) begin
        n_bad++; $display("FAIL rand_pins dut%0d #%0d: got addr=%0d ub=%0d lb=%0d dw=%0d ce=%0d rdy=%0d bad cycles want 0",
                          d, i, obs_addr_bad, obs_ub_bad, obs_lb_bad, obs_dw_bad, obs_ce_high, obs_busy_ready);
      end
      if (obs_lat < 0) break;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 20'h0;
      req_wdata[d] = 16'h0; req_be[d] = 2'b00;
    end
    for (int i = 0; i < NDUT*MSZ; i++) ref_mem[i] = 16'hFFFF;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_zero_be();
    test_back_to_back();
    test_reset_mid_write();
    test_random(1, 1000);
    test_random(2, 1000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
